delay_ram_slave: RTL and testbench

- Memory-side responder for the cache-to-memory port driven by the cache miss handler (`cs`/`we`/`addr`/`din` in, `dout`/`ack`/`stall` out).
- Serves single-word reads and writes from a word-addressed array after a fixed, parameterised latency, so cache miss and write-back timing can be exercised.
- Sits between the cache controller and nothing else; it is the terminal memory model in the cache test tops.

---
 rtl/delay_ram_pkg.sv | 20 ++
 rtl/delay_ram_slave_if.sv | 33 +++
 rtl/delay_ram_array.sv | 36 +++
 rtl/delay_ram_slave.sv | 126 ++++++++++++
 tb/tb_delay_ram_slave.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/delay_ram_pkg.sv
// Shared definitions for the delayed-response memory model: FSM encoding,
// latency counter width and the legal CLK_DELAY range.
package delay_ram_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StAck  = 2'd2
  } state_e;

  localparam int unsigned CNT_WIDTH     = 4;
  localparam int unsigned CLK_DELAY_MIN = 1;
  localparam int unsigned CLK_DELAY_MAX = 15;

  // Value loaded into the latency counter so that ack rises CLK_DELAY edges after acceptance.
  function automatic logic [CNT_WIDTH-1:0] delay_load(input int unsigned delay);
    return CNT_WIDTH'(delay - 1);
  endfunction

endpackage

// File: rtl/delay_ram_slave_if.sv
// Cache-to-memory request/response bundle between the miss handler (master)
// and the memory model (slave).
interface delay_ram_slave_if;

  logic        cs;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  logic        stall;

  modport master (
    output cs,
    output we,
    output addr,
    output din,
    input  dout,
    input  ack,
    input  stall
  );

  modport slave (
    input  cs,
    input  we,
    input  addr,
    input  din,
    output dout,
    output ack,
    output stall
  );

endinterface

// File: rtl/delay_ram_array.sv
// Word storage for delay_ram_slave: synchronous write, registered read data.
// Contents power up to zero and are never touched by reset; only the read register is.
module delay_ram_array #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [Depth] = '{default: '0};
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/delay_ram_slave.sv
// Terminal memory model for cache test tops: answers single-word requests after CLK_DELAY cycles.
// Define DELAY_RAM_SLAVE_STATS_EN to add the rd_count/wr_count access statistics ports.
module delay_ram_slave
  import delay_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CLK_DELAY  = 3
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DELAY_RAM_SLAVE_STATS_EN
  output logic [7:0]        rd_count,
  output logic [7:0]        wr_count,
`endif
  delay_ram_slave_if.slave  bus
);

  if ((CLK_DELAY < CLK_DELAY_MIN) || (CLK_DELAY > CLK_DELAY_MAX)) begin : g_bad_delay
    $error("delay_ram_slave: CLK_DELAY must be in 1..15");
  end

  localparam logic [CNT_WIDTH-1:0] LoadVal = delay_load(CLK_DELAY);

  state_e                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_din;
  logic                  r_ack;
  logic                  r_stall;
  logic                  w_commit;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [31:0]           w_rdata;
  logic                  w_unused_addr;
`ifdef DELAY_RAM_SLAVE_STATS_EN
  logic [7:0]            r_rd_count;
  logic [7:0]            r_wr_count;
`endif

  // Only the word index matters; byte offset and high bits alias.
  assign w_unused_addr = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

  // The access happens on the edge that moves BUSY -> ACK.
  assign w_commit = (r_state == StBusy) && (r_cnt == '0);
  assign w_wr_en  = w_commit & r_we;
  assign w_rd_en  = w_commit & ~r_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_din      <= '0;
      r_ack      <= 1'b0;
      r_stall    <= 1'b0;
`ifdef DELAY_RAM_SLAVE_STATS_EN
      r_rd_count <= '0;
      r_wr_count <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ack <= 1'b0;
          if (bus.cs) begin
            r_state <= StBusy;
            r_we    <= bus.we;
            r_idx   <= bus.addr[ADDR_WIDTH+1:2];
            r_din   <= bus.din;
            r_cnt   <= LoadVal;
            r_stall <= 1'b1;
          end
        end
        StBusy: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= StAck;
            r_ack   <= 1'b1;
            r_stall <= 1'b0;
`ifdef DELAY_RAM_SLAVE_STATS_EN
            if (r_we) begin
              r_wr_count <= r_wr_count + 8'd1;
            end else begin
              r_rd_count <= r_rd_count + 8'd1;
            end
`endif
          end
        end
        StAck: begin
          // Never accepts here, which enforces the CLK_DELAY+2 request spacing.
          r_state <= StIdle;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  delay_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (w_wr_en),
    .i_rd_en (w_rd_en),
    .i_addr  (r_idx),
    .i_wdata (r_din),
    .o_rdata (w_rdata)
  );

  assign bus.dout  = w_rdata;
  assign bus.ack   = r_ack;
  assign bus.stall = r_stall;

`ifdef DELAY_RAM_SLAVE_STATS_EN
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_delay_ram_slave.sv
// Self-checking bench for delay_ram_slave: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_delay_ram_slave;

  localparam int unsigned AW    = 5;
  localparam int unsigned DLY   = 3;
  localparam int unsigned WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst;
`ifdef DELAY_RAM_SLAVE_STATS_EN
  logic [7:0] rd_count;
  logic [7:0] wr_count;
`endif

  delay_ram_slave_if bus ();

  delay_ram_slave #(
    .ADDR_WIDTH (AW),
    .CLK_DELAY  (DLY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DELAY_RAM_SLAVE_STATS_EN
    .rd_count (rd_count),
    .wr_count (wr_count),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_total = 0;
  int          exp_acks  = 0;
  logic [31:0] m_mem [WORDS];
  logic [31:0] exp_dout;

  always @(negedge clk) if (bus.ack === 1'b1) ack_total++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % WORDS;
  endfunction

  task automatic apply_reset();
    bus.cs = 1'b0;
    rst    = 1'b1;
    exp_dout = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One request from an idle DUT; returns one cycle after the ack pulse.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit drop, input bit glitch);
    int lat = 0;
    int st  = 0;
    bit got = 0;
    bus.cs = 1'b1; bus.we = w; bus.addr = a; bus.din = d;
    @(posedge clk); #1;
    check_eq("ack_e0", 32'(bus.ack), 0);
    st += int'(bus.stall);
    if (drop || glitch) bus.cs = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (glitch && lat == 1) begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.din = ~d;
      end
      if (glitch && lat == 2) bus.cs = 1'b0;
      if (bus.ack === 1'b1) got = 1;
      else st += int'(bus.stall);
    end
    check_eq("ack_latency", lat, DLY);
    check_eq("stall_cycles", st, DLY);
    check_eq("stall_at_ack", 32'(bus.stall), 0);
    if (got) exp_acks++;
    if (w) begin
      m_mem[widx(a)] = d;
    end else begin
      exp_dout = m_mem[widx(a)];
      check_eq("rd_data", bus.dout, exp_dout);
    end
    bus.cs = 1'b0;
    @(posedge clk); #1;
    check_eq("ack_pulse_end", 32'(bus.ack), 0);
    check_eq("dout_hold", bus.dout, exp_dout);
  endtask

  initial begin
    int t_ack [2];
    int k;
    int cyc;
    logic [31:0] a;
    foreach (m_mem[i]) m_mem[i] = '0;
    exp_dout = '0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(bus.ack), 0);
    check_eq("rst_stall", 32'(bus.stall), 0);
    check_eq("rst_dout", bus.dout, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write then read, unwritten word, aliasing.
    do_req(1'b1, 32'h08, 32'h5678_0102, 0, 0);
    do_req(1'b0, 32'h08, 32'h0, 0, 0);
    do_req(1'b0, 32'h1C, 32'h0, 0, 0);
    do_req(1'b1, 32'h1C, 32'hCAFE_0011, 0, 0);
    do_req(1'b0, 32'h9C, 32'h0, 0, 0);

    // Two reads with cs held high throughout.
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 32'h08;
    @(posedge clk); #1;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ack === 1'b1) begin
        t_ack[k] = cyc;
        exp_dout = m_mem[widx(k == 0 ? 32'h08 : 32'h1C)];
        check_eq("b2b_rd_data", bus.dout, exp_dout);
        k++;
        exp_acks++;
        bus.addr = 32'h1C;
        if (k == 2) bus.cs = 1'b0;
      end
    end
    check_eq("b2b_ack_count", k, 2);
    check_eq("b2b_first_lat", t_ack[0], DLY);
    check_eq("b2b_spacing", t_ack[1] - t_ack[0], DLY + 2);
    bus.cs = 1'b0;
    @(posedge clk); #1;

    // cs dropped early, and a cs pulse while busy.
    do_req(1'b0, 32'h08, 32'h0, 1, 0);
    do_req(1'b1, 32'h10, 32'h1357_9BDF, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("no_extra_ack", ack_total, exp_acks);
    do_req(1'b0, 32'h10, 32'h0, 0, 0);

    // Reset in the middle of a write must not commit it.
    do_req(1'b1, 32'h04, 32'h1111_2222, 0, 0);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 32'h04; bus.din = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cs = 1'b0;
    #1;
    check_eq("mid_rst_stall", 32'(bus.stall), 0);
    check_eq("mid_rst_ack", 32'(bus.ack), 0);
    check_eq("mid_rst_dout", bus.dout, 0);
    exp_dout = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid_rst_no_ack", ack_total, exp_acks);
    do_req(1'b0, 32'h04, 32'h0, 0, 0);

    // Randomized traffic over a small aliased window.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFF_FF83) | (32'($urandom_range(0, 7)) << 2);
      do_req(1'($urandom_range(0, 1)), a, $urandom, bit'($urandom_range(0, 3) == 0),
             bit'($urandom_range(0, 3) == 0));
    end
    check_eq("rand_ack_total", ack_total, exp_acks);

`ifdef DELAY_RAM_SLAVE_STATS_EN
    apply_reset();
    check_eq("stats_rst_wr", 32'(wr_count), 0);
    check_eq("stats_rst_rd", 32'(rd_count), 0);
    for (int i = 0; i < 3; i++) do_req(1'b1, 32'(i * 4), $urandom, 0, 0);
    for (int i = 0; i < 2; i++) do_req(1'b0, 32'(i * 4), 32'h0, 0, 0);
    check_eq("stats_wr3", 32'(wr_count), 3);
    check_eq("stats_rd2", 32'(rd_count), 2);
    for (int i = 0; i < 253; i++) do_req(1'b1, 32'h40, 32'(i), 0, 0);
    check_eq("stats_wr_wrap", 32'(wr_count), 0);
    check_eq("stats_rd_keep", 32'(rd_count), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
